// File: rtl/gfx_wr_pkg.sv
// Shared types and constants for the two-port graphics write arbiter.
package gfx_wr_pkg;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;

    localparam logic [MASK_W-1:0] MASK_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that did not own the path last.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'b0;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gfx_wr_arbiter.sv
// Shares the DDR address/write-data FIFO pair between the line engine (port 0)
// and the fill/copy engine (port 1), never splitting a 2-beat write.
module gfx_wr_arbiter
    import gfx_wr_pkg::*;
#(
    parameter int MAX_BURSTS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   p0_af_addr_din,
    input  logic                p0_af_wr_en,
    input  logic [DATA_W-1:0]   p0_wdf_din,
    input  logic [MASK_W-1:0]   p0_wdf_mask_din,
    input  logic                p0_wdf_wr_en,
    output logic                p0_af_full,
    output logic                p0_wdf_full,
    input  logic [ADDR_W-1:0]   p1_af_addr_din,
    input  logic                p1_af_wr_en,
    input  logic [DATA_W-1:0]   p1_wdf_din,
    input  logic [MASK_W-1:0]   p1_wdf_mask_din,
    input  logic                p1_wdf_wr_en,
    output logic                p1_af_full,
    output logic                p1_wdf_full,
    input  logic                af_full,
    input  logic                wdf_full,
    output logic [ADDR_W-1:0]   af_addr_din,
    output logic                af_wr_en,
    output logic [DATA_W-1:0]   wdf_din,
    output logic [MASK_W-1:0]   wdf_mask_din,
    output logic                wdf_wr_en,
    output logic [1:0]          gnt,
    output logic                proto_err,
    output logic [1:0]          dbg_state_o
);

    localparam logic [3:0] LAST_BURST = 4'(MAX_BURSTS - 1);

    arb_state_e   state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_owner_q, last_owner_d;
    logic [3:0]   burst_cnt_q, burst_cnt_d;
    logic         proto_err_q, proto_err_d;

    logic               own_af_en, own_wdf_en, oth_af_en;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_data;
    logic [MASK_W-1:0]  own_mask;
    logic               pick_winner, pick_valid;
    logic               beat1_xfer, beat2_xfer;

    rr_pick2 u_pick (
        .req_i    ({p1_af_wr_en, p0_af_wr_en}),
        .last_i   (last_owner_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    always_comb begin
        own_af_en  = owner_q ? p1_af_wr_en     : p0_af_wr_en;
        own_wdf_en = owner_q ? p1_wdf_wr_en    : p0_wdf_wr_en;
        oth_af_en  = owner_q ? p0_af_wr_en     : p1_af_wr_en;
        own_addr   = owner_q ? p1_af_addr_din  : p0_af_addr_din;
        own_data   = owner_q ? p1_wdf_din      : p0_wdf_din;
        own_mask   = owner_q ? p1_wdf_mask_din : p0_wdf_mask_din;
    end

    assign beat1_xfer = (state_q == BEAT1) & own_af_en & own_wdf_en & ~af_full & ~wdf_full;
    assign beat2_xfer = (state_q == BEAT2) & own_wdf_en & ~wdf_full;

    // Next-state logic; valid/ready: a beat moves only in a cycle where the
    // requester's enable is high and the matching p*_full it sees is low.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        proto_err_d  = proto_err_q;
        case (state_q)
            ARB: begin
                if (pick_valid) begin
                    owner_d     = pick_winner;
                    burst_cnt_d = 4'd0;
                    state_d     = BEAT1;
                end
            end
            BEAT1: begin
                if (beat1_xfer) begin
                    state_d = BEAT2;
                end else if (!own_af_en && oth_af_en) begin
                    last_owner_d = owner_q;
                    state_d      = ARB;
                end
            end
            BEAT2: begin
                if (own_af_en) begin
                    proto_err_d = 1'b1;
                end
                if (beat2_xfer) begin
                    if ((burst_cnt_q < LAST_BURST) && !oth_af_en) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                        state_d     = BEAT1;
                    end else begin
                        last_owner_d = owner_q;
                        state_d      = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_comb begin
        af_wr_en     = beat1_xfer;
        wdf_wr_en    = beat1_xfer | beat2_xfer;
        af_addr_din  = '0;
        wdf_din      = '0;
        wdf_mask_din = MASK_NONE;
        gnt          = 2'b00;
        if (state_q != ARB) begin
            af_addr_din  = own_addr;
            wdf_din      = own_data;
            wdf_mask_din = own_mask;
            gnt          = owner_q ? 2'b10 : 2'b01;
        end
    end

    // Only the owner ever sees the real FIFO status; commands are held off in BEAT2.
    always_comb begin
        p0_af_full  = 1'b1;
        p0_wdf_full = 1'b1;
        p1_af_full  = 1'b1;
        p1_wdf_full = 1'b1;
        if (state_q != ARB) begin
            if (owner_q) begin
                p1_af_full  = af_full | (state_q != BEAT1);
                p1_wdf_full = wdf_full;
            end else begin
                p0_af_full  = af_full | (state_q != BEAT1);
                p0_wdf_full = wdf_full;
            end
        end
    end

    assign proto_err   = proto_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gfx_wr_arbiter.sv
// Bench for gfx_wr_arbiter: cycle vector table, reset corner, then a
// per-port scoreboard for arbitration order, burst grouping and FIFO stalls.
module tb_gfx_wr_arbiter;

    localparam int W   = 176;
    localparam int TMO = 200;

    logic         clk, rst;
    logic [30:0]  p0_af_addr_din, p1_af_addr_din, af_addr_din;
    logic         p0_af_wr_en, p1_af_wr_en, p0_wdf_wr_en, p1_wdf_wr_en;
    logic [127:0] p0_wdf_din, p1_wdf_din, wdf_din;
    logic [15:0]  p0_wdf_mask_din, p1_wdf_mask_din, wdf_mask_din;
    logic         p0_af_full, p0_wdf_full, p1_af_full, p1_wdf_full;
    logic         af_full, wdf_full, af_wr_en, wdf_wr_en, proto_err;
    logic [1:0]   gnt, dbg_state;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           log_cyc[$];
    logic [1:0]   log_gnt[$];

    typedef struct packed {
        logic [5:0] in_bits;   // {p0_af, p0_wdf, p1_af, p1_wdf, af_full, wdf_full}
        logic [1:0] e_en;      // {af_wr_en, wdf_wr_en}
        logic [1:0] e_gnt;
        logic [3:0] e_full;    // {p0_af_full, p0_wdf_full, p1_af_full, p1_wdf_full}
        logic [1:0] e_sel;     // 0 idle pattern, 1 port 0 fields, 2 port 1 fields
        logic       e_perr;
    } vec_t;
    vec_t tv[$];

    localparam logic [30:0]  T_A0 = 31'h0001_2340;
    localparam logic [30:0]  T_A1 = 31'h0000_5670;
    localparam logic [127:0] T_D0 = 128'hA0A0_0001_A0A0_0002_A0A0_0003_A0A0_0004;
    localparam logic [127:0] T_D1 = 128'hB1B1_0005_B1B1_0006_B1B1_0007_B1B1_0008;
    localparam logic [15:0]  T_M0 = 16'h0000;
    localparam logic [15:0]  T_M1 = 16'h00F0;

    gfx_wr_arbiter #(.MAX_BURSTS(4)) dut (
        .clk(clk), .rst(rst),
        .p0_af_addr_din(p0_af_addr_din), .p0_af_wr_en(p0_af_wr_en),
        .p0_wdf_din(p0_wdf_din), .p0_wdf_mask_din(p0_wdf_mask_din),
        .p0_wdf_wr_en(p0_wdf_wr_en), .p0_af_full(p0_af_full), .p0_wdf_full(p0_wdf_full),
        .p1_af_addr_din(p1_af_addr_din), .p1_af_wr_en(p1_af_wr_en),
        .p1_wdf_din(p1_wdf_din), .p1_wdf_mask_din(p1_wdf_mask_din),
        .p1_wdf_wr_en(p1_wdf_wr_en), .p1_af_full(p1_af_full), .p1_wdf_full(p1_wdf_full),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .gnt(gnt), .proto_err(proto_err), .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] i, input logic [1:0] en, input logic [1:0] g,
                                input logic [3:0] f, input logic [1:0] s, input logic p);
        vec_t v;
        v.in_bits = i; v.e_en = en; v.e_gnt = g; v.e_full = f; v.e_sel = s; v.e_perr = p;
        return v;
    endfunction

    // Driver tasks
    task automatic drive(input int p, input logic af, input logic wd, input logic [30:0] a,
                         input logic [127:0] d, input logic [15:0] m);
        if (p == 0) begin
            p0_af_wr_en = af; p0_wdf_wr_en = wd; p0_af_addr_din = a; p0_wdf_din = d; p0_wdf_mask_din = m;
        end else begin
            p1_af_wr_en = af; p1_wdf_wr_en = wd; p1_af_addr_din = a; p1_wdf_din = d; p1_wdf_mask_din = m;
        end
    endtask

    task automatic do_burst(input int p, input logic [30:0] a, input logic [127:0] d0,
                            input logic [127:0] d1, input logic [15:0] m0, input logic [15:0] m1);
        logic ok;
        int   n;
        if (p == 0) begin
            exp_q0.push_back({1'b1, a, d0, m0});
            exp_q0.push_back({1'b0, 31'h0, d1, m1});
        end else begin
            exp_q1.push_back({1'b1, a, d0, m0});
            exp_q1.push_back({1'b0, 31'h0, d1, m1});
        end
        drive(p, 1'b1, 1'b1, a, d0, m0);
        ok = 1'b0; n = 0;
        while (!ok && n < TMO) begin
            @(negedge clk);
            ok = (p == 0) ? (!p0_af_full && !p0_wdf_full) : (!p1_af_full && !p1_wdf_full);
            @(posedge clk); #1;
            n++;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL beat1_timeout port%0d: got no accept expected accept within %0d cycles", p, TMO);
        end
        drive(p, 1'b0, 1'b1, a, d1, m1);
        ok = 1'b0; n = 0;
        while (!ok && n < TMO) begin
            @(negedge clk);
            ok = (p == 0) ? !p0_wdf_full : !p1_wdf_full;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL beat2_timeout port%0d: got no accept expected accept within %0d cycles", p, TMO);
        end
        drive(p, 1'b0, 1'b0, 31'h0, 128'h0, 16'h0);
    endtask

    task automatic rand_burst(input int p);
        do_burst(p, 31'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] got, idle_pat, p0_pat, p1_pat, sel_pat;
    logic         rand_done;

    initial begin
        rst = 1'b0; af_full = 1'b0; wdf_full = 1'b0;
        drive(0, 1'b0, 1'b0, 31'h0, 128'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 31'h0, 128'h0, 16'h0);

        // Scoreboard monitor: sample away from the active edge
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (mon_en && (af_wr_en || wdf_wr_en)) begin
                    chk("fifo_full_respected", {(af_wr_en & (af_full | wdf_full)) | (wdf_wr_en & wdf_full)}, '0);
                    chk("af_implies_wdf", {af_wr_en & ~wdf_wr_en}, '0);
                    if (af_wr_en) begin
                        log_cyc.push_back(cyc);
                        log_gnt.push_back(gnt);
                    end
                    got = {af_wr_en, (af_wr_en ? af_addr_din : 31'h0), wdf_din, wdf_mask_din};
                    if (gnt == 2'b01 && exp_q0.size() > 0) begin
                        chk("port0_write", got, exp_q0.pop_front());
                    end else if (gnt == 2'b10 && exp_q1.size() > 0) begin
                        chk("port1_write", got, exp_q1.pop_front());
                    end else begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_write: got gnt=%b data=%0h expected no write", gnt, got);
                    end
                end
            end
        join_none

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", gnt, 2'b00);
        chk("reset_full", {p0_af_full, p0_wdf_full, p1_af_full, p1_wdf_full}, 4'b1111);
        chk("reset_en", {af_wr_en, wdf_wr_en}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;

        // Cycle table starting from the post-reset ARB state
        tv.push_back(mk(6'b000000, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b0));
        tv.push_back(mk(6'b110000, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b0));
        tv.push_back(mk(6'b110000, 2'b11, 2'b01, 4'b0011, 2'd1, 1'b0));
        tv.push_back(mk(6'b010001, 2'b00, 2'b01, 4'b1111, 2'd1, 1'b0));
        tv.push_back(mk(6'b010001, 2'b00, 2'b01, 4'b1111, 2'd1, 1'b0));
        tv.push_back(mk(6'b010000, 2'b01, 2'b01, 4'b1011, 2'd1, 1'b0));
        tv.push_back(mk(6'b000000, 2'b00, 2'b01, 4'b0011, 2'd1, 1'b0));
        tv.push_back(mk(6'b110010, 2'b00, 2'b01, 4'b1011, 2'd1, 1'b0));
        tv.push_back(mk(6'b110000, 2'b11, 2'b01, 4'b0011, 2'd1, 1'b0));
        tv.push_back(mk(6'b011100, 2'b01, 2'b01, 4'b1011, 2'd1, 1'b0));
        tv.push_back(mk(6'b111100, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b0));
        tv.push_back(mk(6'b111100, 2'b11, 2'b10, 4'b1100, 2'd2, 1'b0));
        tv.push_back(mk(6'b111100, 2'b01, 2'b10, 4'b1110, 2'd2, 1'b0));
        tv.push_back(mk(6'b110000, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b1));
        tv.push_back(mk(6'b001100, 2'b00, 2'b01, 4'b0011, 2'd1, 1'b1));
        tv.push_back(mk(6'b001100, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b1));
        tv.push_back(mk(6'b001100, 2'b11, 2'b10, 4'b1100, 2'd2, 1'b1));

        idle_pat = {1'b0, 31'h0, 128'h0, 16'hFFFF};
        p0_pat   = {1'b0, T_A0, T_D0, T_M0};
        p1_pat   = {1'b0, T_A1, T_D1, T_M1};
        for (int i = 0; i < tv.size(); i++) begin
            drive(0, tv[i].in_bits[5], tv[i].in_bits[4], T_A0, T_D0, T_M0);
            drive(1, tv[i].in_bits[3], tv[i].in_bits[2], T_A1, T_D1, T_M1);
            af_full  = tv[i].in_bits[1];
            wdf_full = tv[i].in_bits[0];
            @(negedge clk);
            sel_pat = (tv[i].e_sel == 2'd1) ? p0_pat : (tv[i].e_sel == 2'd2) ? p1_pat : idle_pat;
            chk($sformatf("row%0d_en", i), {af_wr_en, wdf_wr_en}, tv[i].e_en);
            chk($sformatf("row%0d_gnt", i), gnt, tv[i].e_gnt);
            chk($sformatf("row%0d_full", i), {p0_af_full, p0_wdf_full, p1_af_full, p1_wdf_full}, tv[i].e_full);
            chk($sformatf("row%0d_data", i), {1'b0, af_addr_din, wdf_din, wdf_mask_din}, sel_pat);
            chk($sformatf("row%0d_perr", i), proto_err, tv[i].e_perr);
            @(posedge clk); #1;
        end

        // Reset while port 1 sits in BEAT2
        drive(0, 1'b0, 1'b0, 31'h0, 128'h0, 16'h0);
        drive(1, 1'b0, 1'b1, T_A1, T_D1, T_M1);
        af_full = 1'b0; wdf_full = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("pre_reset_gnt", gnt, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 31'h0, 128'h0, 16'h0);
        @(negedge clk);
        chk("midreset_gnt", gnt, 2'b00);
        chk("midreset_en", {af_wr_en, wdf_wr_en}, 2'b00);
        chk("midreset_perr", proto_err, 1'b0);
        chk("midreset_full", {p0_af_full, p0_wdf_full, p1_af_full, p1_wdf_full}, 4'b1111);
        @(posedge clk); #1;

        // Both ports streaming: strict alternation, port 0 first
        mon_en = 1'b1;
        log_cyc.delete(); log_gnt.delete();
        fork
            begin for (int i = 0; i < 4; i++) rand_burst(0); end
            begin for (int i = 0; i < 4; i++) rand_burst(1); end
        join
        idle_cycles(4);
        chk("alt_count", log_gnt.size(), 8);
        for (int k = 0; k < log_gnt.size() && k < 8; k++)
            chk($sformatf("alt_owner%0d", k), log_gnt[k], (k % 2 == 1) ? 2'b10 : 2'b01);

        // Port 0 alone: groups of four bursts, one ARB cycle between groups
        log_cyc.delete(); log_gnt.delete();
        for (int i = 0; i < 10; i++) rand_burst(0);
        idle_cycles(4);
        chk("stream_count", log_cyc.size(), 10);
        for (int k = 1; k < log_cyc.size() && k < 10; k++)
            chk($sformatf("stream_gap%0d", k), log_cyc[k] - log_cyc[k-1], (k % 4 == 0) ? 3 : 2);

        // Random FIFO backpressure with both ports active
        rand_done = 1'b0;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 6; i++) begin
                            idle_cycles($urandom_range(0, 2));
                            rand_burst(0);
                        end
                    end
                    begin
                        for (int i = 0; i < 6; i++) begin
                            idle_cycles($urandom_range(0, 2));
                            rand_burst(1);
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    af_full  = ($urandom_range(0, 3) == 0);
                    wdf_full = ($urandom_range(0, 3) == 0);
                    @(posedge clk); #1;
                end
                af_full = 1'b0; wdf_full = 1'b0;
            end
        join
        idle_cycles(6);
        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);
        chk("final_perr", proto_err, 1'b0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gfx_wr_arbiter.md
Name: gfx_wr_arbiter

Overview:
- Shares the single DDR write path (address FIFO af_*, write-data FIFO wdf_*) between two graphics requesters: port 0 = line engine, port 1 = frame filler / block-copy engine.
- Each requester issues 2-beat writes: beat 1 carries the address command and the first 128-bit data word; beat 2 carries the second 128-bit data word. The arbiter never interleaves beats of different requesters.
- Sits between the graphics engines and the memory-controller FIFOs. To each requester it presents per-port af_full/wdf_full so that it appears to be the FIFO.

Parameters:
- MAX_BURSTS, 4: maximum consecutive 2-beat writes one owner may issue before forced re-arbitration. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets)
- p0_af_addr_din  in  31  port 0 command address
- p0_af_wr_en  in  1  port 0 command valid (beat 1)
- p0_wdf_din  in  128  port 0 write data
- p0_wdf_mask_din  in  16  port 0 byte mask (1 = byte not written)
- p0_wdf_wr_en  in  1  port 0 data valid
- p0_af_full  out  1  stall to port 0, command
- p0_wdf_full  out  1  stall to port 0, data
- p1_*  same 7 signals for port 1
- af_full  in  1  address FIFO full
- wdf_full  in  1  write-data FIFO full
- af_addr_din  out  31  to address FIFO
- af_wr_en  out  1  to address FIFO
- wdf_din  out  128  to write-data FIFO
- wdf_mask_din  out  16  to write-data FIFO
- wdf_wr_en  out  1  to write-data FIFO
- gnt  out  2  one-hot current owner (00 = none)
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Requester protocol:
  - Beat 1: p*_af_wr_en=1 and p*_wdf_wr_en=1. Signals are held until accepted while the port's full outputs are high.
  - Beat 2: p*_wdf_wr_en=1, p*_af_wr_en=0, held until accepted.
- States: ARB, BEAT1, BEAT2. Registers: owner (1b), last_owner (1b), burst_cnt (4b), proto_err.
- Reset (rst==0 at clk edge):
  - state=ARB, owner=0, last_owner=1 (so port 0 wins the first tie), burst_cnt=0, proto_err=0.
  - All FIFO outputs deasserted; gnt=00; all p*_full=1.
  - Reset mid-burst drops the partial burst. Requesters are reset by the same rst.
- ARB state:
  - Nothing is forwarded; both ports see full=1.
  - Request = p*_af_wr_en.
  - Only one port requesting: grant it.
  - Both requesting: grant !last_owner (round-robin).
  - None requesting: stay in ARB.
  - On grant: owner<=winner, burst_cnt<=0, next state BEAT1. Grant latency = 1 cycle.
- Forwarding (BEAT1/BEAT2):
  - af_addr_din/wdf_din/wdf_mask_din = owner's inputs.
  - In ARB, outputs are driven as 0 with mask 16'hFFFF.
  - Owner's p_af_full = af_full | (state!=BEAT1); owner's p_wdf_full = wdf_full.
  - Non-owner always sees both full=1.
- BEAT1 state:
  - af_wr_en = owner af_wr_en & owner wdf_wr_en & !af_full & !wdf_full. wdf_wr_en takes the same value.
  - Accept → BEAT2.
  - Owner af_wr_en=0 and other port requesting → last_owner<=owner, go to ARB (release).
  - Owner idle and other idle → hold BEAT1.
  - Owner af_wr_en=1 with wdf_wr_en=0 → no transfer, wait.
- BEAT2 state:
  - af_wr_en=0; wdf_wr_en = owner wdf_wr_en & !wdf_full.
  - On accept:
    - If burst_cnt < MAX_BURSTS-1 and other port's af_wr_en=0: burst_cnt++, go to BEAT1 (same owner).
    - Otherwise: last_owner<=owner, go to ARB.
  - Owner af_wr_en=1 during BEAT2 sets proto_err (sticky until reset); the beat is still processed as data-only.
- Simultaneous events:
  - af_full/wdf_full are sampled in the same cycle as the enables. No transfer occurs in a cycle with full=1.
  - A request arriving on the other port during BEAT2 acceptance forces ARB. It never pre-empts a burst in progress.
- Throughput:
  - Same owner: sustained 2 beats per 2 cycles, no bubbles.
  - Each re-arbitration costs 1 idle cycle (ARB).
- gnt = one-hot(owner) in BEAT1/BEAT2, 00 in ARB.

Decomposition:
- Package gfx_wr_pkg: state encoding (ARB=2'd0, BEAT1=2'd1, BEAT2=2'd2), MASK_NONE=16'hFFFF, ADDR_W=31, DATA_W=128, MASK_W=16.
- One sub-module, rr_pick2: combinational 2-way round-robin picker (req[1:0], last → winner, valid).
- Muxes and the FSM stay in the top level.

Test Plan:
- Single port 0 write, addr=31'h0001_2340, two beats data A/B, fulls=0 → af_wr_en and wdf_wr_en high in cycle 2 with addr/A, wdf_wr_en high in cycle 3 with B; gnt=01; p1 fulls stay 1.
- Both ports request beat 1 in the same cycle after reset → port 0 granted first; after its burst (port 1 still requesting), ARB grants port 1; strict alternation over 8 bursts.
- Port 0 streams 10 back-to-back bursts, port 1 idle, MAX_BURSTS=4 → bursts in groups of 4 separated by one ARB cycle; no bubble inside a group.
- wdf_full=1 for 3 cycles during BEAT2 → wdf_wr_en low for those 3 cycles, data B forwarded on the first cycle full=0, no duplicate; af_wr_en never asserted in BEAT2.
- Port 1 asserts af_wr_en during BEAT2 → proto_err=1 and stays 1; the data beat completes normally.
- rst=0 asserted while in BEAT2 → next cycle state ARB, gnt=00, all FIFO enables 0, proto_err=0.
